// File: rtl/up_down_counter_host.sv
// Bus initiator for the 8-bit up/down counter: validates one configuration command,
// writes PLR/ULR/LLR/CCR, optionally reads them back, then starts the counter and waits for ec.
module up_down_counter_host #(
    parameter int RD_WAIT = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cfg_plr,
    input  logic [7:0] cfg_ulr,
    input  logic [7:0] cfg_llr,
    input  logic [7:0] cfg_ccr,
    input  logic       verify_en,
    inout  wire  [7:0] Din,
    output logic       ncs,
    output logic       nrd,
    output logic       nwr,
    output logic       A1,
    output logic       A0,
    output logic       start,
    input  logic       ec,
    input  logic       err,
    output logic       busy,
    output logic       done,
    output logic [3:0] status
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WRITE, S_GAP1, S_READ, S_GAP2, S_START, S_WAIT_EC, S_DONE
    } state_t;

    localparam logic [2:0]  RD_LAST = 3'(RD_WAIT);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_idx, w_idx_nxt;
    logic [2:0]  r_wt, w_wt_nxt;
    logic [15:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [3:0]  r_status, w_status_nxt;
    logic [7:0]  r_plr, r_ulr, r_llr, r_ccr;
    logic        r_verify;
    logic [7:0]  w_rd_exp, w_wr_val, r_dout;
    logic        r_doe, r_ncs, r_nrd, r_nwr, r_start, r_done, r_ready, r_busy;
    logic [1:0]  r_addr;
    logic        w_accept, w_cfg_bad;

    function automatic logic [7:0] sel_reg(input logic [1:0] idx, input logic [7:0] plr,
                                           input logic [7:0] ulr, input logic [7:0] llr,
                                           input logic [7:0] ccr);
        case (idx)
            2'd0:    return plr;
            2'd1:    return ulr;
            2'd2:    return llr;
            default: return ccr;
        endcase
    endfunction

    assign w_accept  = cmd_valid && (r_state == S_IDLE);
    assign w_cfg_bad = (r_plr < r_llr) || (r_plr > r_ulr) || (r_llr > r_ulr);
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_rd_exp  = sel_reg(r_idx, r_plr, r_ulr, r_llr, r_ccr);
    assign w_wr_val  = sel_reg(w_idx_nxt, r_plr, r_ulr, r_llr, r_ccr);

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_wt_nxt     = r_wt;
        w_cnt_nxt    = r_cnt;
        w_status_nxt = r_status;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_CHECK;
                    w_status_nxt = 4'b0000;
                end
            end
            S_CHECK: begin
                if (w_cfg_bad) begin
                    w_status_nxt[0] = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_state_nxt = S_WRITE;
                    w_idx_nxt   = 2'd0;
                end
            end
            S_WRITE: begin
                if (r_idx == 2'd3) w_state_nxt = S_GAP1;
                else               w_idx_nxt   = r_idx + 2'd1;
            end
            S_GAP1: begin
                if (r_verify) begin
                    w_state_nxt = S_READ;
                    w_idx_nxt   = 2'd0;
                    w_wt_nxt    = 3'd0;
                end else begin
                    w_state_nxt = S_GAP2;
                end
            end
            S_READ: begin
                // Din is sampled only on the last held cycle of each address
                if (r_wt == RD_LAST) begin
                    if (Din != w_rd_exp) w_status_nxt[1] = 1'b1;
                    w_wt_nxt = 3'd0;
                    if (r_idx == 2'd3) w_state_nxt = S_GAP2;
                    else               w_idx_nxt   = r_idx + 2'd1;
                end else begin
                    w_wt_nxt = r_wt + 3'd1;
                end
            end
            S_GAP2: begin
                if (r_status[1]) begin
                    w_state_nxt = S_DONE;
                end else if (err) begin
                    w_status_nxt[3] = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_state_nxt = S_WAIT_EC;
                w_cnt_nxt   = 16'd0;
            end
            S_WAIT_EC: begin
                w_cnt_nxt = w_cnt_inc;
                // ec has priority over a simultaneous err or an expiring timeout
                if (ec) begin
                    w_state_nxt = S_DONE;
                end else if (err) begin
                    w_status_nxt[3] = 1'b1;
                    w_state_nxt     = S_DONE;
                end else if (w_cnt_inc == TO_LAST) begin
                    w_status_nxt[2] = 1'b1;
                    w_state_nxt     = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they are stable for the whole cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_wt     <= 3'd0;
            r_cnt    <= 16'd0;
            r_status <= 4'b0000;
            r_ncs    <= 1'b1;
            r_nrd    <= 1'b1;
            r_nwr    <= 1'b1;
            r_addr   <= 2'b00;
            r_start  <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_doe    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_wt     <= w_wt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_status <= w_status_nxt;
            r_ncs    <= !(w_state_nxt inside {S_WRITE, S_READ, S_START, S_WAIT_EC});
            r_nrd    <= (w_state_nxt != S_READ);
            r_nwr    <= (w_state_nxt != S_WRITE);
            r_addr   <= (w_state_nxt == S_WRITE || w_state_nxt == S_READ) ? w_idx_nxt : 2'b00;
            r_start  <= (w_state_nxt == S_START);
            r_done   <= (w_state_nxt == S_DONE);
            r_ready  <= (w_state_nxt == S_IDLE);
            r_busy   <= (w_state_nxt != S_IDLE);
            r_doe    <= (w_state_nxt == S_WRITE);
        end
    end

    always_ff @(posedge clk) begin
        r_dout <= w_wr_val;
        if (w_accept) begin
            r_plr    <= cfg_plr;
            r_ulr    <= cfg_ulr;
            r_llr    <= cfg_llr;
            r_ccr    <= cfg_ccr;
            r_verify <= verify_en;
        end
    end

    assign Din       = r_doe ? r_dout : 8'bz;
    assign ncs       = r_ncs;
    assign nrd       = r_nrd;
    assign nwr       = r_nwr;
    assign A1        = r_addr[1];
    assign A0        = r_addr[0];
    assign start     = r_start;
    assign done      = r_done;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign status    = r_status;

endmodule

// File: tb/tb_up_down_counter_host.sv
// Randomized and directed bench for up_down_counter_host, checked against a
// sequence-level timing model derived from the command rules.
module tb_up_down_counter_host;

    localparam int RD_WAIT = 1;
    localparam int TIMEOUT = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [7:0] cfg_plr = 8'd0, cfg_ulr = 8'd0, cfg_llr = 8'd0, cfg_ccr = 8'd0;
    logic       verify_en = 1'b0;
    wire  [7:0] Din;
    logic       ncs, nrd, nwr, A1, A0, start, busy, done, cmd_ready;
    logic       ec = 1'b0, err = 1'b0;
    logic [3:0] status;

    int total = 0;
    int bad = 0;

    // Register-file model of the counter: echoes written values, optional corruption
    logic [7:0] mem [4];
    logic       corrupt_en = 1'b0;
    logic [1:0] corrupt_addr = 2'd0;
    logic [7:0] corrupt_val = 8'd0;
    logic       tb_probe = 1'b0;
    logic [7:0] w_tb_dout;

    assign w_tb_dout = (corrupt_en && {A1, A0} == corrupt_addr) ? corrupt_val : mem[{A1, A0}];
    assign Din = tb_probe ? 8'h00 : ((!ncs && !nrd) ? w_tb_dout : 8'bz);

    up_down_counter_host #(.RD_WAIT(RD_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cfg_plr(cfg_plr), .cfg_ulr(cfg_ulr), .cfg_llr(cfg_llr), .cfg_ccr(cfg_ccr),
        .verify_en(verify_en), .Din(Din), .ncs(ncs), .nrd(nrd), .nwr(nwr),
        .A1(A1), .A0(A0), .start(start), .ec(ec), .err(err),
        .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    // Observations of one sequence
    logic [1:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         rd_cnt, st_cnt, st_cyc, dn_cyc;
    logic [3:0] dn_status;
    logic       dn_ncs, ncs_seen, busy_bad, rdy_bad;

    // Expected results
    int         e_done, e_start, e_reads, e_writes;
    logic [3:0] e_status;

    task automatic predict(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                           input logic [7:0] c, input logic v, input int ec_at, input int err_at);
        logic [7:0] regs [4];
        int gap2, s;
        regs[0] = p; regs[1] = u; regs[2] = l; regs[3] = c;
        e_start = -1;
        if (p < l || p > u || l > u) begin
            e_done = 2; e_reads = 0; e_writes = 0; e_status = 4'b0001;
            return;
        end
        e_writes = 4;
        e_reads  = v ? 4 * (RD_WAIT + 1) : 0;
        gap2     = v ? 7 + 4 * (RD_WAIT + 1) : 7;
        if (v && corrupt_en && corrupt_val != regs[corrupt_addr]) begin
            e_done = gap2 + 1; e_status = 4'b0010;
        end else if (err_at == gap2) begin
            e_done = gap2 + 1; e_status = 4'b1000;
        end else begin
            s = gap2 + 1;
            e_start = s;
            e_done = s + TIMEOUT;
            e_status = 4'b0100;
            for (int cy = s + TIMEOUT - 1; cy > s; cy--) begin
                if (ec_at == cy) begin
                    e_done = cy + 1; e_status = 4'b0000;
                end else if (err_at == cy) begin
                    e_done = cy + 1; e_status = 4'b1000;
                end
            end
        end
    endtask

    task automatic run_seq(input logic [7:0] p, input logic [7:0] u, input logic [7:0] l,
                           input logic [7:0] c, input logic v, input int ec_at, input int err_at);
        cfg_plr = p; cfg_ulr = u; cfg_llr = l; cfg_ccr = c; verify_en = v;
        for (int i = 0; i < 4; i++) mem[i] = 8'd0;
        wr_addr.delete(); wr_data.delete();
        rd_cnt = 0; st_cnt = 0; st_cyc = -1; dn_cyc = -1; dn_status = 4'd0;
        dn_ncs = 1'b0; ncs_seen = 1'b0; busy_bad = 1'b0; rdy_bad = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 200 && dn_cyc < 0; k++) begin
            ec  = (k == ec_at);
            err = (k == err_at);
            if (!ncs) ncs_seen = 1'b1;
            if (!ncs && !nwr) begin
                wr_addr.push_back({A1, A0});
                wr_data.push_back(Din);
                mem[{A1, A0}] = Din;
            end
            if (!ncs && !nrd) rd_cnt++;
            if (start) begin
                st_cnt++;
                if (st_cyc < 0) st_cyc = k;
            end
            if (!busy) busy_bad = 1'b1;
            if (cmd_ready) rdy_bad = 1'b1;
            if (done) begin
                dn_cyc = k; dn_status = status; dn_ncs = ncs;
            end
            @(posedge clk);
            #1;
        end
        ec = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({ncs, nrd, nwr} !== 3'b111) begin bad++; $display("FAIL reset_strobes got=%b want=111", {ncs, nrd, nwr}); end
        total++; if ({A1, A0, start, busy, done} !== 5'b0) begin bad++; $display("FAIL reset_misc got=%b want=00000", {A1, A0, start, busy, done}); end
        total++; if (cmd_ready !== 1'b1 || status !== 4'd0) begin bad++; $display("FAIL reset_ready_status got=%b/%b want=1/0000", cmd_ready, status); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (cmd_ready !== 1'b1 || ncs !== 1'b1) begin bad++; $display("FAIL post_reset_idle got=%b%b want=11", cmd_ready, ncs); end
    endtask

    task automatic test_verify_ok();
        predict(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 40, -1);
        run_seq(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 40, -1);
        total++; if (wr_addr.size() !== e_writes) begin bad++; $display("FAIL vok_nwrites got=%0d want=%0d", wr_addr.size(), e_writes); end
        for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
            total++;
            if (wr_addr[i] !== 2'(i) || wr_data[i] !== (i == 0 ? 8'd10 : i == 1 ? 8'd15 : i == 2 ? 8'd5 : 8'd2)) begin
                bad++; $display("FAIL vok_write%0d got=%0d@%0d", i, wr_data[i], wr_addr[i]);
            end
        end
        total++; if (rd_cnt !== e_reads) begin bad++; $display("FAIL vok_reads got=%0d want=%0d", rd_cnt, e_reads); end
        total++; if (st_cyc !== 16 || st_cnt !== 1) begin bad++; $display("FAIL vok_start got=%0d x%0d want=16 x1", st_cyc, st_cnt); end
        total++; if (dn_cyc !== e_done || dn_status !== e_status) begin bad++; $display("FAIL vok_done got=%0d/%b want=%0d/%b", dn_cyc, dn_status, e_done, e_status); end
        total++; if (busy_bad || rdy_bad) begin bad++; $display("FAIL vok_busy_ready got=%b%b want=00", busy_bad, rdy_bad); end
        total++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL vok_idle_after got=%b%b%b want=100", cmd_ready, busy, done); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (status !== e_status) begin bad++; $display("FAIL vok_status_hold got=%b want=%b", status, e_status); end
    endtask

    task automatic test_cfg_err();
        predict(8'd20, 8'd15, 8'd5, 8'd0, 1'b1, -1, -1);
        run_seq(8'd20, 8'd15, 8'd5, 8'd0, 1'b1, -1, -1);
        total++; if (ncs_seen !== 1'b0) begin bad++; $display("FAIL cfg_no_bus got=%b want=0", ncs_seen); end
        total++; if (dn_cyc !== e_done || dn_status !== e_status) begin bad++; $display("FAIL cfg_done got=%0d/%b want=%0d/%b", dn_cyc, dn_status, e_done, e_status); end
    endtask

    task automatic test_mismatch();
        corrupt_en = 1'b1; corrupt_addr = 2'd2; corrupt_val = 8'd6;
        predict(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, -1, -1);
        run_seq(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, -1, -1);
        corrupt_en = 1'b0;
        total++; if (rd_cnt !== 4 * (RD_WAIT + 1)) begin bad++; $display("FAIL mis_reads got=%0d want=%0d", rd_cnt, 4 * (RD_WAIT + 1)); end
        total++; if (st_cnt !== 0) begin bad++; $display("FAIL mis_nostart got=%0d want=0", st_cnt); end
        total++; if (dn_cyc !== e_done || dn_status !== 4'b0010) begin bad++; $display("FAIL mis_done got=%0d/%b want=%0d/0010", dn_cyc, dn_status, e_done); end
    endtask

    task automatic test_timeout();
        predict(8'd3, 8'd9, 8'd1, 8'd4, 1'b0, -1, -1);
        run_seq(8'd3, 8'd9, 8'd1, 8'd4, 1'b0, -1, -1);
        total++; if (st_cyc !== 8 || dn_cyc !== st_cyc + TIMEOUT) begin bad++; $display("FAIL to_done got=%0d start=%0d want=%0d", dn_cyc, st_cyc, 8 + TIMEOUT); end
        total++; if (dn_status !== 4'b0100 || dn_ncs !== 1'b1) begin bad++; $display("FAIL to_status got=%b ncs=%b want=0100 ncs=1", dn_status, dn_ncs); end
        total++; if (ncs !== 1'b1) begin bad++; $display("FAIL to_ncs_after got=%b want=1", ncs); end
    endtask

    task automatic test_dev_err();
        predict(8'd7, 8'd7, 8'd7, 8'd1, 1'b0, -1, 7);
        run_seq(8'd7, 8'd7, 8'd7, 8'd1, 1'b0, -1, 7);
        total++; if (st_cnt !== 0 || dn_status !== 4'b1000 || dn_cyc !== e_done) begin bad++; $display("FAIL deverr_gap2 got=%0d/%b/%0d want=0/1000/%0d", st_cnt, dn_status, dn_cyc, e_done); end
        predict(8'd7, 8'd9, 8'd2, 8'd1, 1'b0, 20, 20);
        run_seq(8'd7, 8'd9, 8'd2, 8'd1, 1'b0, 20, 20);
        total++; if (dn_status !== 4'b0000 || dn_cyc !== 21) begin bad++; $display("FAIL ec_err_same got=%b/%0d want=0000/21", dn_status, dn_cyc); end
        predict(8'd7, 8'd9, 8'd2, 8'd1, 1'b0, -1, 15);
        run_seq(8'd7, 8'd9, 8'd2, 8'd1, 1'b0, -1, 15);
        total++; if (dn_status !== e_status || dn_cyc !== e_done) begin bad++; $display("FAIL deverr_wait got=%b/%0d want=%b/%0d", dn_status, dn_cyc, e_status, e_done); end
    endtask

    task automatic test_reset_mid();
        int dones;
        cfg_plr = 8'd10; cfg_ulr = 8'd15; cfg_llr = 8'd5; cfg_ccr = 8'd2; verify_en = 1'b1;
        @(negedge clk); cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if (nrd !== 1'b0 || {A1, A0} !== 2'b01) begin bad++; $display("FAIL rmid_in_read got=%b/%b want=0/01", nrd, {A1, A0}); end
        #2 reset = 1'b0; tb_probe = 1'b1;
        #1;
        total++; if ({ncs, nrd, nwr} !== 3'b111 || Din !== 8'h00) begin bad++; $display("FAIL rmid_idle got=%b din=%h want=111 din=00", {ncs, nrd, nwr}, Din); end
        dones = 0;
        repeat (4) begin @(posedge clk); #1; if (done) dones++; end
        total++; if (dones !== 0) begin bad++; $display("FAIL rmid_no_done got=%0d want=0", dones); end
        @(negedge clk); reset = 1'b1; tb_probe = 1'b0;
        // Reset while the start pulse is high
        cfg_plr = 8'd4; cfg_ulr = 8'd8; cfg_llr = 8'd0; verify_en = 1'b0;
        @(negedge clk); cmd_valid = 1'b1;
        @(posedge clk); #1; cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        total++; if (start !== 1'b1) begin bad++; $display("FAIL rstart_pre got=%b want=1", start); end
        #2 reset = 1'b0;
        #1;
        total++; if (start !== 1'b0 || ncs !== 1'b1) begin bad++; $display("FAIL rstart_drop got=%b%b want=01", start, ncs); end
        @(negedge clk); reset = 1'b1;
        predict(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 30, -1);
        run_seq(8'd10, 8'd15, 8'd5, 8'd2, 1'b1, 30, -1);
        total++; if (wr_addr.size() !== 4 || st_cyc !== e_start || dn_cyc !== e_done || dn_status !== e_status) begin
            bad++; $display("FAIL rmid_rerun got=%0d/%0d/%0d/%b want=4/%0d/%0d/%b", wr_addr.size(), st_cyc, dn_cyc, dn_status, e_start, e_done, e_status);
        end
    endtask

    task automatic test_random();
        logic [7:0] p, u, l, c;
        logic v;
        int ec_at, err_at;
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                p = 8'($urandom); u = 8'($urandom); l = 8'($urandom);
            end else begin
                l = 8'($urandom_range(0, 200));
                u = l + 8'($urandom_range(0, 55));
                p = l + 8'($urandom_range(0, int'(u - l)));
            end
            c = 8'($urandom);
            v = 1'($urandom);
            ec_at  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(9, 70));
            err_at = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 60));
            corrupt_en = ($urandom_range(0, 3) == 0);
            corrupt_addr = 2'($urandom);
            corrupt_val = 8'($urandom);
            predict(p, u, l, c, v, ec_at, err_at);
            run_seq(p, u, l, c, v, ec_at, err_at);
            corrupt_en = 1'b0;
            total++; if (dn_cyc !== e_done || dn_status !== e_status) begin bad++; $display("FAIL rnd%0d_done got=%0d/%b want=%0d/%b", it, dn_cyc, dn_status, e_done, e_status); end
            total++; if (st_cyc !== e_start || rd_cnt !== e_reads || wr_addr.size() !== e_writes) begin
                bad++; $display("FAIL rnd%0d_bus got=%0d/%0d/%0d want=%0d/%0d/%0d", it, st_cyc, rd_cnt, wr_addr.size(), e_start, e_reads, e_writes);
            end
        end
    endtask

    initial begin
        test_reset();
        test_verify_ok();
        test_cfg_err();
        test_mismatch();
        test_timeout();
        test_dev_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/up_down_counter_host.md
# up_down_counter_host

Bus-initiator for the 8-bit up/down counter's register interface (PLR/ULR/LLR/CCR via Din/ncs/nrd/nwr/A1:A0, plus start/ec/err). It accepts one configuration command, validates it, and writes the four registers. It optionally reads them back and compares them, then issues the start pulse and waits for end-of-cycle. It sits between a control FSM or CPU-side logic and the counter, replacing hand-driven bus stimulus.

## Interface
- RD_WAIT, 1: extra cycles a read access is held before Din is sampled (0..7)
- TIMEOUT, 1024: max cycles spent in WAIT_EC before abort (16-bit counter)

Ports:
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  asynchronous, active-low; clears all state and returns the bus to idle immediately
- cmd_valid  in  1  request a program/run sequence
- cmd_ready  out  1  high only in IDLE
- cfg_plr, cfg_ulr, cfg_llr, cfg_ccr  in  8 each  preload, upper limit, lower limit, cycle count
- verify_en  in  1  enables the read-back phase; latched with the command
- Din  inout  8  driven only in write cycles, hi-Z otherwise
- ncs, nrd, nwr  out  1 each  active-low bus strobes
- A1, A0  out  1 each  register select: 00 PLR, 01 ULR, 10 LLR, 11 CCR
- start  out  1  one-cycle start pulse to the counter
- ec, err  in  1 each  counter end-of-cycle and limit-error flags
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at sequence end
- status  out  4  valid with done and held until next accept: [0] cfg_err, [1] mismatch, [2] timeout, [3] dev_err

## Operation
- States: IDLE, CHECK, WRITE, GAP1, READ, GAP2, START, WAIT_EC, DONE.
- Accept: cmd_valid && cmd_ready at a posedge. At that edge cfg_* and verify_en are latched, status is cleared, and the FSM moves to CHECK.
- CHECK (1 cycle):
  - If PLR<LLR, PLR>ULR or LLR>ULR, set cfg_err and go to DONE. No bus activity occurs.
  - Otherwise go to WRITE.
- WRITE: 4 cycles with index 0..3 giving A1:A0 = 00, 01, 10, 11.
  - ncs=0, nwr=0, nrd=1.
  - Din is driven with PLR, ULR, LLR, CCR respectively.
- GAP1: 1 cycle with ncs=nwr=nrd=1 and Din hi-Z.
  - If verify_en, go to READ.
  - Otherwise go to GAP2.
- READ: for each address 00..11, hold ncs=0, nrd=0, nwr=1 for RD_WAIT+1 cycles.
  - Din is sampled at the posedge ending the last cycle of each address.
  - Any difference from the latched value sets mismatch. All four addresses are always read.
- GAP2: 1 cycle, bus idle; err is sampled.
  - If mismatch: go to DONE.
  - Else if err=1: set dev_err and go to DONE.
  - Otherwise go to START.
- START: 1 cycle with start=1, ncs=0, nrd=nwr=1.
- WAIT_EC: ncs=0, other strobes high. A 16-bit counter increments each cycle.
  - ec=1 goes to DONE.
  - err=1 sets dev_err and goes to DONE.
  - If the counter reaches TIMEOUT-1 without ec, set timeout and go to DONE.
  - If ec and err are seen on the same edge, ec wins and dev_err is not set.
- DONE: done=1 for 1 cycle, ncs=1, then return to IDLE.
- Commands presented while busy are ignored because cmd_ready=0.

## Timing
- Reset values: ncs=nrd=nwr=1, A1=A0=0, start=0, Din hi-Z, cmd_ready=1, busy=0, done=0, status=0.
- All outputs are registered. Strobes, address and Din change only just after a posedge and are stable for the whole cycle, so the counter samples them on the following posedge.
- Counting cycle 0 as the accept edge, with a valid config and verify_en=0:
  - CHECK = cycle 1.
  - Writes = cycles 2-5.
  - GAP1 = 6, GAP2 = 7, start = cycle 8.
- With verify_en=1 and RD_WAIT=1:
  - Reads = cycles 7-14.
  - GAP2 = 15, start = cycle 16.
- done asserts the cycle after the terminating event is seen. With an invalid config, done is at cycle 2.
- Din is never driven in a cycle where nrd=0. At least one idle cycle separates the last write from the first read.
- Reset asserted mid-sequence forces the idle bus values asynchronously. No done is produced, and start is dropped even mid-pulse.

## Test plan
- Config PLR=10, ULR=15, LLR=5, CCR=2, verify_en=1, model echoes registers: writes 10/15/5/2 to addresses 00/01/10/11, read-back matches, start at cycle 16, ec at cycle 40 -> done with status=0000.
- Config PLR=20, ULR=15, LLR=5 -> no ncs assertion, done at cycle 2, status=0001.
- Model corrupts the LLR read to 6 -> all 4 reads occur, no start pulse, status=0010.
- ec never asserts, TIMEOUT=32 -> done 32 cycles after the start cycle, status=0100, ncs returns to 1.
- Model holds err=1 in GAP2 -> no start, status=1000. Separately, err and ec rising on the same edge in WAIT_EC -> status=0000.
- Reset pulled low during READ address 01 -> ncs/nrd/nwr=1 and Din hi-Z immediately. No done. A new command after reset release runs a full sequence.
